lifo_fifo_buffer: RTL and testbench

Parametrised storage buffer that generalises the lab's 4-bit × 8 stack. It runs as a LIFO (stack) or a FIFO (queue), selected at run time, and exposes an occupancy count plus sticky overflow/underflow error flags. Simultaneous push and pop are serviced in the same cycle rather than ignored. It sits between a producer and a consumer on a single clock domain and is the team's standard small buffer for later lab designs.

---
 rtl/lifo_fifo_buffer.sv | 173 +++++++++++++++++
 tb/tb_lifo_fifo_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lifo_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : lifo_fifo_buffer
//  Purpose  : DEPTH x WIDTH storage buffer, run-time selectable LIFO / FIFO,
//             with occupancy count, registered full/empty and sticky
//             overflow/underflow flags. Simultaneous push+pop serviced.
//  Revision : 1.0  initial release
// ============================================================================
module lifo_fifo_buffer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       mode,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
    localparam logic [CW-1:0] c_DEPTH   = CW'(DEPTH);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

    // Storage array; deliberately not reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    sp_q, sp_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [CW-1:0]    sp_m1;
    logic [AW-1:0]    top_idx;
    logic             is_empty;
    logic             is_full;

    // Next-state decode of the request pair against the pre-edge state.
    always_comb begin
        count_d    = count_q;
        sp_d       = sp_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mode_d     = mode_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        wr_en      = 1'b0;
        wr_addr    = '0;

        is_empty = (count_q == '0);
        is_full  = (count_q == c_DEPTH);
        sp_m1    = sp_q - c_CNT_ONE;
        top_idx  = sp_m1[AW-1:0];

        // Mode may only change while nothing is stored and nothing is about
        // to be stored; a bypass stores nothing, so it does not block it.
        if (is_empty && !(push && !pop)) begin
            mode_d = mode;
        end

        case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = mode_q ? wr_ptr_q : sp_q[AW-1:0];
                    if (mode_q) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
                    count_d = count_q + c_CNT_ONE;
                    sp_d    = sp_q + c_CNT_ONE;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    data_out_d = mode_q ? mem_q[rd_ptr_q] : mem_q[top_idx];
                    valid_d    = 1'b1;
                    if (mode_q) rd_ptr_d = rd_ptr_q + c_PTR_ONE;
                    count_d = count_q - c_CNT_ONE;
                    sp_d    = sp_m1;
                end
            end
            2'b11: begin
                valid_d = 1'b1;
                if (is_empty) begin
                    data_out_d = data_in;
                end else begin
                    // Read old contents and overwrite/append in one edge;
                    // occupancy is unchanged.
                    data_out_d = mode_q ? mem_q[rd_ptr_q] : mem_q[top_idx];
                    wr_en      = 1'b1;
                    wr_addr    = mode_q ? wr_ptr_q : top_idx;
                    if (mode_q) begin
                        wr_ptr_d = wr_ptr_q + c_PTR_ONE;
                        rd_ptr_d = rd_ptr_q + c_PTR_ONE;
                    end
                end
            end
            default: ;
        endcase

        full_d  = (count_d == c_DEPTH);
        empty_d = (count_d == '0);
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            count_q    <= '0;
            sp_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mode_q     <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            sp_q       <= sp_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mode_q     <= mode_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Array write port; gated by reset so a request during reset is dropped.
    always_ff @(posedge clk) begin
        if (rstN && wr_en) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_lifo_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lifo_fifo_buffer
//  Purpose  : Self-checking bench for lifo_fifo_buffer: queue-based reference
//             model, per-cycle compare, directed scenarios and random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lifo_fifo_buffer;

    localparam int W = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rstN;
    logic         mode;
    logic         push;
    logic         pop;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic         valid_out;
    logic         full;
    logic         empty;
    logic [3:0]   count;
    logic         overflow;
    logic         underflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    lifo_fifo_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rstN(rstN), .mode(mode), .push(push), .pop(pop),
        .data_in(data_in), .data_out(data_out), .valid_out(valid_out),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue; LIFO pops the back, FIFO the front.
    logic [W-1:0] mq[$];
    bit           m_mode = 1'b0;
    logic [W-1:0] m_dout = '0;
    bit           m_valid = 1'b0;
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;

    always @(posedge clk) begin
        bit was_empty;
        if (!rstN) begin
            mq.delete();
            m_mode = 1'b0; m_dout = '0; m_valid = 1'b0;
            m_ovf = 1'b0;  m_unf = 1'b0;
        end else begin
            m_valid   = 1'b0;
            was_empty = (mq.size() == 0);
            if (was_empty && !(push && !pop)) m_mode = mode;
            if (push && pop) begin
                m_valid = 1'b1;
                if (was_empty) m_dout = data_in;
                else begin
                    m_dout = m_mode ? mq.pop_front() : mq.pop_back();
                    mq.push_back(data_in);
                end
            end else if (push) begin
                if (mq.size() == D) m_ovf = 1'b1;
                else mq.push_back(data_in);
            end else if (pop) begin
                if (was_empty) m_unf = 1'b1;
                else begin
                    m_dout  = m_mode ? mq.pop_front() : mq.pop_back();
                    m_valid = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (data_out !== m_dout || valid_out !== m_valid ||
                count !== 4'(mq.size()) || full !== (mq.size() == D) ||
                empty !== (mq.size() == 0) || overflow !== m_ovf ||
                underflow !== m_unf) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got dout=%0h v=%0b cnt=%0d f=%0b e=%0b ov=%0b un=%0b exp dout=%0h v=%0b cnt=%0d ov=%0b un=%0b",
                         $time, data_out, valid_out, count, full, empty, overflow, underflow,
                         m_dout, m_valid, mq.size(), m_ovf, m_unf);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic po, input logic [W-1:0] d, input logic m);
        push = p; pop = po; data_in = d; mode = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0; mode = 1'b0;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk_en = 1'b1;
        lit("reset_count", count, 0);
        lit("reset_empty", empty, 1);
        lit("reset_dout", data_out, 0);
        rstN = 1'b1;

        // LIFO push 1,2,3 then pop x3
        drive(1, 0, 1, 0); drive(1, 0, 2, 0); drive(1, 0, 3, 0);
        lit("lifo_count3", count, 3);
        for (int i = 3; i >= 1; i--) begin
            drive(0, 1, 0, 0);
            lit("lifo_pop", data_out, i);
            lit("lifo_valid", valid_out, 1);
        end
        lit("lifo_empty", empty, 1);

        // FIFO fill, overflow, drain in order
        drive(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) drive(1, 0, 4'(i), 1);
        lit("fifo_full", full, 1);
        lit("fifo_count8", count, 8);
        drive(1, 0, 4'hF, 1);
        lit("fifo_overflow", overflow, 1);
        lit("fifo_ovf_count", count, 8);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 1);
            lit("fifo_pop", data_out, i);
        end

        // FIFO wrap: push 6, pop 4, push 5, pop 7
        for (int i = 0; i < 6; i++) drive(1, 0, 4'(i + 3), 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 1);
            lit("wrap_pop_a", data_out, i + 3);
        end
        for (int i = 0; i < 5; i++) drive(1, 0, 4'(i + 9), 1);
        drive(0, 1, 0, 1); lit("wrap_pop_b", data_out, 7);
        drive(0, 1, 0, 1); lit("wrap_pop_b", data_out, 8);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 1);
            lit("wrap_pop_c", data_out, i + 9);
        end
        lit("wrap_empty", empty, 1);
        lit("wrap_no_underflow", underflow, 0);

        // Simultaneous push/pop in LIFO
        drive(0, 0, 0, 0);
        drive(1, 0, 1, 0); drive(1, 0, 2, 0);
        drive(1, 1, 9, 0);
        lit("pp_dout", data_out, 2);
        lit("pp_count", count, 2);
        drive(0, 1, 0, 0); lit("pp_pop9", data_out, 9);
        drive(0, 1, 0, 0); lit("pp_pop1", data_out, 1);

        // Bypass on empty
        drive(1, 1, 5, 0);
        lit("bypass_dout", data_out, 5);
        lit("bypass_valid", valid_out, 1);
        lit("bypass_count", count, 0);

        // Underflow
        drive(0, 1, 0, 0);
        lit("underflow_flag", underflow, 1);
        lit("underflow_dout", data_out, 5);
        lit("underflow_valid", valid_out, 0);

        // Mode change while count=2 ignored
        drive(1, 0, 1, 0); drive(1, 0, 2, 0);
        drive(0, 0, 0, 1);
        drive(0, 1, 0, 1); lit("mode_ignored", data_out, 2);
        drive(0, 1, 0, 1); lit("mode_ignored2", data_out, 1);

        // Reset mid-FIFO with count=3
        drive(0, 0, 0, 1);
        drive(1, 0, 7, 1); drive(1, 0, 8, 1); drive(1, 0, 9, 1);
        lit("pre_reset_count", count, 3);
        rstN = 1'b0;
        drive(0, 0, 0, 1);
        rstN = 1'b1;
        lit("rst_count", count, 0);
        lit("rst_empty", empty, 1);
        lit("rst_full", full, 0);
        lit("rst_ovf", overflow, 0);
        lit("rst_unf", underflow, 0);
        lit("rst_dout", data_out, 0);
        drive(1, 0, 4, 1); drive(1, 0, 6, 1);
        drive(0, 1, 0, 1); lit("rst_lifo_pop6", data_out, 6);
        drive(0, 1, 0, 1); lit("rst_pop4", data_out, 4);

        // Randomised traffic with phases biased toward fill and drain
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 200) % 2 == 0) ? 70 : 30;
            rstN = ($urandom_range(0, 199) != 0);
            drive(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) < (100 - bias)),
                  4'($urandom), 1'($urandom));
        end
        rstN = 1'b1;
        drive(0, 0, 0, 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
